input_port_rx: RTL
==================

INPUT_PORT_RX -- requirements
Module: input_port_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range is an even value from 4 to 1024.
REQ-002 Parameter FIFO_DEPTH, default 4: received-byte buffer entries; legal values are powers of 2 from 2 to 16.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port RXD, input, 1 bit: asynchronous serial line, 8N1 framing, LSB first, idle high.
REQ-006 Port INP_CLR, input, 1 bit: CPU consumes the head byte (INP instruction); sampled each clk.
REQ-007 Port ERR_CLR, input, 1 bit: clears the sticky error flags.
REQ-008 Port INPR, output, 8 bits: FIFO head byte; 8'h00 when the FIFO is empty.
REQ-009 Port FGI, output, 1 bit: input flag; 1 exactly when the FIFO is non-empty.
REQ-010 Port OVR, output, 1 bit: sticky overrun flag.
REQ-011 Port FERR, output, 1 bit: sticky framing-error flag.

Function
REQ-012 RXD SHALL pass through a 2-flop synchronizer before any use; all RXD timing below is measured at the synchronizer output (rxs).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, with a bit-timer counter and a 3-bit bit index.
REQ-014 IDLE: a 1->0 transition on rxs SHALL move the FSM to START and load the timer.
REQ-015 START: at CLKS_PER_BIT/2 cycles after the edge, rxs SHALL be sampled; 0 -> DATA, 1 -> IDLE (false start, no flag raised).
REQ-016 DATA: each bit SHALL be sampled CLKS_PER_BIT cycles after the previous sample and shifted in LSB first; after bit 7 the FSM moves to STOP.
REQ-017 STOP: rxs SHALL be sampled CLKS_PER_BIT cycles after bit 7; 1 -> push the byte, 0 -> discard the byte and set FERR; in both cases the FSM returns to IDLE.
REQ-018 After a stop sample of 0, the FSM SHALL NOT re-arm until rxs has been observed high (break tolerance).
REQ-019 A push SHALL write the FIFO tail; FGI and INPR SHALL reflect the new state on the cycle after the stop sample.
REQ-020 INP_CLR=1 with FIFO non-empty SHALL pop the head; INPR shows the next byte (or 8'h00) and FGI updates on the following cycle.
REQ-021 INP_CLR=1 with FIFO empty SHALL have no effect.
REQ-022 Push with FIFO full and no simultaneous pop SHALL drop the new byte, set OVR, and leave FIFO contents unchanged.
REQ-023 Push and pop in the same cycle SHALL both occur, including when the FIFO is full (no overrun) and when it holds one entry.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with an extra pointer bit or a count from 0 to FIFO_DEPTH.
REQ-025 OVR and FERR SHALL remain set until ERR_CLR=1; if a set event and ERR_CLR coincide, the set SHALL win.
REQ-026 Byte reception SHALL continue independently of the FIFO level and of INP_CLR activity.

Reset
REQ-027 While rst_n=0: FSM=IDLE, timer=0, bit index=0, shift register=0, FIFO empty, both pointers 0, synchronizer flops=1.
REQ-028 While rst_n=0: INPR=8'h00, FGI=0, OVR=0, FERR=0, taking effect immediately without a clock edge.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no push and no flag set.
REQ-030 After rst_n deasserts, a new frame SHALL be accepted only after a fresh falling edge.

Verification
REQ-031 One frame 8'hA5 with CLKS_PER_BIT=16 -> FGI=1 and INPR=8'hA5 one cycle after the stop sample; INP_CLR pulse -> FGI=0, INPR=8'h00.
REQ-032 Frames 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 with no INP_CLR and depth 4 -> OVR=1; four pops return 11, 22, 33, 44 in order; the fifth pop has no effect.
REQ-033 Frame 8'h3C with stop bit forced to 0 -> FERR=1, FGI unchanged; ERR_CLR -> FERR=0.
REQ-034 Low glitch of 3 cycles on RXD -> no push, no flags, FSM back in IDLE.
REQ-035 FIFO full, INP_CLR asserted in the same cycle as the fifth stop sample -> OVR=0, occupancy stays 4, head advances.
REQ-036 rst_n pulsed low during bit 4 of a frame -> all outputs 0 asynchronously; the next clean frame 8'h7E is received correctly.

Source files
------------

// File: rtl/input_port_rx.sv
// Serial 8N1 receiver feeding a small byte FIFO for the CPU input port.
// Sticky overrun and framing-error flags are cleared by ERR_CLR.
module input_port_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RXD,
  input  logic       INP_CLR,
  input  logic       ERR_CLR,
  output logic [7:0] INPR,
  output logic       FGI,
  output logic       OVR,
  output logic       FERR
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] HalfLoad = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FullLoad = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          rx_meta_q, rxs_q, rxs_prev_q;
  logic          push, ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          empty, full, pop, push_ok, ovr_set;
  logic          ovr_q, ferr_q;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= RXD;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Only a genuine falling edge arms a frame, so a held-low break after a
  // framing error cannot restart reception until the line returns high.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d = StStart;
          timer_d = HalfLoad;
        end
      end
      StStart: begin
        if (timer_q == '0) begin
          if (!rxs_q) begin
            state_d = StData;
            timer_d = FullLoad;
            idx_d   = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StData: begin
        if (timer_q == '0) begin
          shreg_d = {rxs_q, shreg_q[7:1]};
          timer_d = FullLoad;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StStop: begin
        if (timer_q == '0) begin
          state_d = StIdle;
          if (rxs_q) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = INP_CLR && !empty;
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_q[AW-1:0]] <= shreg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (ovr_set)      ovr_q <= 1'b1;
      else if (ERR_CLR) ovr_q <= 1'b0;
      if (ferr_set)     ferr_q <= 1'b1;
      else if (ERR_CLR) ferr_q <= 1'b0;
    end
  end

  assign INPR = empty ? 8'h00 : mem[rd_q[AW-1:0]];
  assign FGI  = !empty;
  assign OVR  = ovr_q;
  assign FERR = ferr_q;

endmodule
